arb4_rr_ctrl: RTL and testbench
===============================

ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req  input  4  per-requester request for the shared write resource; bit i = requester i.
REQ-005 SHALL have port done  input  1  current owner finished; sampled only while granted.
REQ-006 SHALL have port gnt  output  4  one-hot grant; all zero when no owner.
REQ-007 SHALL have port gnt_sel  output  2  binary index of current owner; drives the 2-to-4 decoder sel.
REQ-008 SHALL have port gnt_en  output  1  grant valid; drives the 2-to-4 decoder en.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (owner = gnt_sel).
REQ-011 SHALL hold a 2-bit round-robin pointer ptr; priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 SHALL, in IDLE with req != 0 at a rising edge, enter GRANT with the highest-priority requesting index; gnt/gnt_sel/gnt_en visible after that edge (1-cycle latency).
REQ-013 SHALL, in IDLE with req == 0, remain in IDLE; done ignored in IDLE.
REQ-014 SHALL maintain hold counter cnt, cleared to 0 on every new grant (including handoff), incremented each GRANT cycle without release.
REQ-015 SHALL release the owner at an edge where done=1, or req[gnt_sel]=0, or cnt == MAX_HOLD-1.
REQ-016 SHALL, on release, set ptr = (owner+1) mod 4 and arbitrate req in the same edge with the updated ptr.
REQ-017 SHALL, on release with a winner, grant it at that edge with no idle bubble; with no requester, enter IDLE with gnt_en=0.
REQ-018 SHALL allow the releasing owner to be re-granted only when it is the sole requester (lowest priority after ptr update).
REQ-019 SHALL assert timeout for exactly the one cycle following a release caused solely by cnt == MAX_HOLD-1 (done=0 and req[owner]=1); otherwise timeout=0.
REQ-020 SHALL give done priority over timeout when both apply at the same edge (timeout stays 0).
REQ-021 SHALL keep gnt == (1 << gnt_sel) when gnt_en=1 and gnt == 0 when gnt_en=0, all outputs registered.
REQ-022 SHALL not change owner while in GRANT for requests by other indices; their req bits only affect the next arbitration.
REQ-023 SHALL size cnt to hold MAX_HOLD-1 with no wrap; cnt never exceeds MAX_HOLD-1.

Reset
REQ-024 SHALL, while reset_n=0, force gnt=0000, gnt_sel=00, gnt_en=0, timeout=0, ptr=0, cnt=0, state IDLE, immediately (no clock needed).
REQ-025 SHALL abandon any active grant on reset assertion mid-GRANT; after release of reset, first grant follows REQ-012 with ptr=0.

Verification
REQ-026 Basic grant: reset, req=0100 -> next edge gnt=0100, gnt_sel=10, gnt_en=1; drop req -> next edge gnt_en=0, ptr=3.
REQ-027 Round robin: req=1111 held, done=1 every grant cycle -> owners 0,1,2,3,0 on consecutive cycles, no bubbles, timeout=0.
REQ-028 Timeout: MAX_HOLD=8, req=0011, done=0 -> owner 0 for exactly 8 cycles, then owner 1, timeout=1 for one cycle coinciding with owner 1's first cycle.
REQ-029 Sole requester: req=0001 held, done=0 -> owner 0 re-granted after each timeout, 8-cycle periods, timeout pulses each period, gnt_en never drops.
REQ-030 Simultaneous done and timeout: done=1 at cnt=7 -> handoff occurs, timeout stays 0.
REQ-031 Reset mid-grant: owner 2 granted, reset_n=0 between edges -> outputs zero immediately; after reset_n=1, req=1100 -> owner 2 (ptr=0 scan 0,1,2).

Source files
------------

// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter for a shared write resource, with a
// per-owner hold limit that forces a release and flags it with a timeout pulse.
module arb4_rr_ctrl #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_sel,
  output logic       gnt_en,
  output logic       timeout
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             to_q, to_d;
  logic             at_max;
  logic             release_now;

  // First requester found scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign at_max      = (cnt_q == CNT_MAX);
  assign release_now = done | ~req[sel_q] | at_max;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = rr_pick(req, ptr_q);
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + 2'd1;
          // A forced release only counts when nothing else explains it.
          to_d  = at_max & ~done & req[sel_q];
          cnt_d = '0;
          if (|req) begin
            sel_d = rr_pick(req, ptr_d);
            en_d  = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = 2'd0;
            en_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        sel_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
    gnt_d = en_d ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      gnt_q   <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_sel = sel_q;
  assign gnt_en  = en_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed-vector bench for arb4_rr_ctrl: the driver queues hand-computed
// outputs per cycle, a monitor pops and compares them after each rising edge.
module tb_arb4_rr_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_sel;
  logic       gnt_en;
  logic       timeout;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  arb4_rr_ctrl #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_sel (gnt_sel),
    .gnt_en  (gnt_en),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [1:0] owner,
                      input logic en, input logic to);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.gnt = en ? (4'b0001 << owner) : 4'b0000;
    e.sel = en ? owner : 2'd0;
    e.en  = en;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (gnt !== 4'b0000 || gnt_sel !== 2'b00 || gnt_en !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d en=%b to=%b, want all zero",
               name, gnt, gnt_sel, gnt_en, timeout);
    end else begin
      $display("check %s: outputs zero", name);
    end
  endtask

  // Monitor: compare once per cycle whenever a response is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if (gnt !== e.gnt || gnt_sel !== e.sel || gnt_en !== e.en || timeout !== e.to) begin
          errors++;
          $display("FAIL txn%0d: got gnt=%b sel=%0d en=%b to=%b, want gnt=%b sel=%0d en=%b to=%b",
                   txn, gnt, gnt_sel, gnt_en, timeout, e.gnt, e.sel, e.en, e.to);
        end else begin
          $display("txn%0d: gnt=%b sel=%0d en=%b to=%b", txn, gnt, gnt_sel, gnt_en, timeout);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    req     = 4'b0000;
    done    = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic grant and release; release of owner 2 leaves ptr=3.
    step(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 2'd3, 1'b1, 1'b0);

    // Round robin with done every cycle: 0,1,2,3,0,1,2,3 with no bubbles.
    for (int i = 0; i < 8; i++)
      step(4'b1111, 1'b1, 2'(i % 4), 1'b1, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);   // ptr now 0

    // Hold limit: owner 0 for 8 cycles, then owner 1 with a timeout pulse.
    for (int i = 0; i < 8; i++)
      step(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++)
      step(4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
    // Owner 1 now at cnt=7: done at the limit hands off without timeout.
    step(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);   // ptr now 1

    // Sole requester: re-granted every 8 cycles with a pulse, grant never drops.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++)
        step(4'b0001, 1'b0, 2'd0, 1'b1, (p > 0 && i == 0));
    step(4'b0001, 1'b0, 2'd0, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);   // ptr now 1

    // Reset while owner 2 holds the grant.
    step(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    req     = 4'b0000;
    #1 check_zero("reset_midgrant");
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1100, 1'b0, 2'd2, 1'b1, 1'b0);   // ptr=0 scan 0,1,2
    step(4'b1100, 1'b1, 2'd3, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
